fft_mag_calc: RTL and testbench
===============================

Name: fft_mag_calc

Overview:
- Sits between the FFT core's complex output stream and the LCD spectrum top level, which consumes fft_data/fft_sop/fft_eop/fft_valid.
- Converts each complex bin to an approximate 16-bit unsigned magnitude using alpha-max-plus-beta-min: max + 3/8*min.
- Forwards only the first OUT_BINS bins of each frame (the positive-frequency half), with its own sop/eop framing.
- Drops the rest of the frame and flags framing errors. Single clock domain (50 MHz).

Parameters:
- FFT_LEN, 128, number of bins per input frame (power of 2, 4..1024).
- OUT_BINS, 64, bins forwarded per frame; 1 <= OUT_BINS <= FFT_LEN.
- CNT_W, 10, bin counter width; must satisfy 2^CNT_W >= FFT_LEN.

Ports:
- clk_50m  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- src_real  in  16  signed real part of the bin.
- src_imag  in  16  signed imaginary part of the bin.
- src_sop  in  1  first bin of the frame; qualified by src_valid.
- src_eop  in  1  last bin of the frame; qualified by src_valid.
- src_valid  in  1  input beat valid. No backpressure; the block accepts every beat.
- fft_data  out  16  unsigned magnitude.
- fft_sop  out  1  first forwarded bin.
- fft_eop  out  1  last forwarded bin.
- fft_valid  out  1  output beat valid.
- frame_err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (asynchronous, active-high):
  - fft_data=0, fft_sop=0, fft_eop=0, fft_valid=0, frame_err=0.
  - Pipeline valid bits cleared; FSM goes to IDLE; bin counter = 0.
- Framing FSM acts on input beats (src_valid=1 only). States: IDLE, PASS, DROP.
  - IDLE: a beat with src_sop=1 -> counter=0. The beat is forwarded with a sop tag. Next state is PASS, or DROP if OUT_BINS==1.
    - A beat without sop is discarded and frame_err pulses.
  - PASS: each beat is forwarded and the counter increments.
    - The beat with counter==OUT_BINS-1 gets an eop tag; next state DROP.
  - DROP: beats are discarded until src_eop=1, then IDLE.
  - The OUT_BINS==1 case tags both sop and eop on the first beat.
- Input src_eop in PASS before OUT_BINS bins (early eop):
  - The beat is forwarded with an eop tag (truncated frame).
  - frame_err pulses; next state IDLE.
- src_sop in PASS or DROP (restart):
  - If in PASS, the previous output frame is never closed; frame_err pulses.
  - The new frame starts as from IDLE on the same beat: forwarded with a sop tag, counter=0.
- src_sop and src_eop on the same beat from IDLE (single-bin frame): forwarded with both sop and eop tags. frame_err pulses only if OUT_BINS>1.
- Counter reaching FFT_LEN-1 without src_eop: no special action. DROP continues until eop or sop.
- Magnitude pipeline: fixed 3-cycle latency from an accepted beat to fft_valid; sop/eop tags are carried alongside.
  - S1: a=|re|, b=|im| as 16-bit unsigned; |-32768| = 32768.
  - S2: mx=max(a,b), mn=min(a,b).
  - S3: fft_data = mx + (mn>>2) + (mn>>3), truncating shifts. Maximum 45056 fits 16 bits, so no saturation is needed.
- Discarded beats produce no output and no bubble-shift side effects; gaps in src_valid pass through as gaps in fft_valid.
- fft_sop, fft_eop, and fft_data are meaningful only when fft_valid=1. fft_sop and fft_eop are 0 whenever fft_valid=0; fft_data holds its last value.
- frame_err is registered and asserted in the cycle after the offending input beat. It is independent of pipeline latency.
- Throughput: one beat per clock, sustained.

Test Plan:
- Single beat re=3000, im=-4000 as a sop beat (OUT_BINS=64) -> 3 cycles later fft_valid=1, fft_data=5125, fft_sop=1, fft_eop=0.
- re=-32768, im=-32768 -> fft_data=45056 (0xB000). re=0, im=0 -> fft_data=0. re=100, im=100 -> 137.
- Full 128-bin frame, back-to-back, FFT_LEN=128, OUT_BINS=64 -> exactly 64 output beats; sop on the 1st, eop on the 64th; bins 64..127 produce no output; frame_err stays 0. Second identical frame reproduces the same output.
- Same frame with src_valid deasserted every 3rd cycle -> identical 64 magnitudes in order, gaps mirrored 3 cycles later.
- Early eop on bin 10 -> 11 output beats, eop on the 11th; frame_err pulses once.
- New sop at bin 20 -> 20 beats with no eop, then a new sop beat; frame_err pulses.
- Beats with no sop after reset -> no output; one frame_err pulse per beat.
- Assert rst mid-frame at bin 30 while the pipeline is full -> outputs go to 0 immediately. After release, input resumes with no sop -> nothing forwarded until the next src_sop.

Source files
------------

// File: rtl/fft_mag_calc.sv
// Converts the FFT core's complex bin stream to alpha-max-plus-beta-min magnitudes.
// Only the first OUT_BINS bins of each frame are forwarded, each frame with its own sop/eop.
module fft_mag_calc #(
  parameter int FFT_LEN  = 128,
  parameter int OUT_BINS = 64,
  parameter int CNT_W    = 10
) (
  input  logic               clk_50m,
  input  logic               rst,
  input  logic signed [15:0] src_real,
  input  logic signed [15:0] src_imag,
  input  logic               src_sop,
  input  logic               src_eop,
  input  logic               src_valid,
  output logic        [15:0] fft_data,
  output logic               fft_sop,
  output logic               fft_eop,
  output logic               fft_valid,
  output logic               frame_err
);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_BINS - 1);
  localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(FFT_LEN - 1);
  localparam bit               ONE_BIN  = (OUT_BINS == 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;   // bin index of the next input beat
  logic             fwd, tag_sop, tag_eop, err;

  logic        s1_valid, s1_sop, s1_eop;
  logic        s2_valid, s2_sop, s2_eop;
  logic [15:0] s1_a, s1_b, s2_mx, s2_mn;

  function automatic logic [15:0] abs16(input logic signed [15:0] x);
    logic [15:0] ux;
    ux = x;
    return x[15] ? (~ux + 16'd1) : ux;
  endfunction

  // NOTE: every variable gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fwd       = 1'b0;
    tag_sop   = 1'b0;
    tag_eop   = 1'b0;
    err       = 1'b0;
    if (src_valid) begin
      if (src_sop) begin
        fwd     = 1'b1;
        tag_sop = 1'b1;
        cnt_nxt = CNT_W'(1);
        err     = (state == PASS);
        if (src_eop) begin
          tag_eop   = 1'b1;
          state_nxt = IDLE;
          if (!ONE_BIN) err = 1'b1;
        end else if (ONE_BIN) begin
          tag_eop   = 1'b1;
          state_nxt = DROP;
        end else begin
          state_nxt = PASS;
        end
      end else begin
        unique case (state)
          IDLE: err = 1'b1;
          PASS: begin
            fwd     = 1'b1;
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == OUT_LAST) begin
              tag_eop   = 1'b1;
              state_nxt = src_eop ? IDLE : DROP;
            end else if (src_eop) begin
              tag_eop   = 1'b1;
              err       = 1'b1;
              state_nxt = IDLE;
            end
          end
          DROP: begin
            if (cnt != LEN_LAST) cnt_nxt = cnt + CNT_W'(1);
            if (src_eop) state_nxt = IDLE;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      s1_valid  <= 1'b0;
      s1_sop    <= 1'b0;
      s1_eop    <= 1'b0;
      s2_valid  <= 1'b0;
      s2_sop    <= 1'b0;
      s2_eop    <= 1'b0;
      fft_valid <= 1'b0;
      fft_sop   <= 1'b0;
      fft_eop   <= 1'b0;
      fft_data  <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      frame_err <= err;
      s1_valid  <= fwd;
      s1_sop    <= tag_sop;
      s1_eop    <= tag_eop;
      s2_valid  <= s1_valid;
      s2_sop    <= s1_sop;
      s2_eop    <= s1_eop;
      fft_valid <= s2_valid;
      fft_sop   <= s2_valid & s2_sop;
      fft_eop   <= s2_valid & s2_eop;
      // Worst case 32768 + 8192 + 4096 = 45056 still fits 16 bits.
      if (s2_valid) fft_data <= s2_mx + (s2_mn >> 2) + (s2_mn >> 3);
    end
  end

  // NOTE: datapath registers carry no reset; the valid bits alone decide whether they matter.
  always_ff @(posedge clk_50m) begin
    if (fwd) begin
      s1_a <= abs16(src_real);
      s1_b <= abs16(src_imag);
    end
    if (s1_valid) begin
      s2_mx <= (s1_a >= s1_b) ? s1_a : s1_b;
      s2_mn <= (s1_a >= s1_b) ? s1_b : s1_a;
    end
  end

endmodule

// File: tb/tb_fft_mag_calc.sv
// Directed bench for fft_mag_calc: scoreboard of expected beats (value, tags, arrival cycle)
// plus a one-cycle-delayed expectation of frame_err.
module tb_fft_mag_calc;

  localparam int FFT_LEN  = 128;
  localparam int OUT_BINS = 64;

  logic               clk_50m = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] src_real = '0, src_imag = '0;
  logic               src_sop = 1'b0, src_eop = 1'b0, src_valid = 1'b0;
  logic        [15:0] fft_data;
  logic               fft_sop, fft_eop, fft_valid, frame_err;

  fft_mag_calc #(.FFT_LEN(FFT_LEN), .OUT_BINS(OUT_BINS), .CNT_W(10)) dut (
    .clk_50m(clk_50m), .rst(rst),
    .src_real(src_real), .src_imag(src_imag),
    .src_sop(src_sop), .src_eop(src_eop), .src_valid(src_valid),
    .fft_data(fft_data), .fft_sop(fft_sop), .fft_eop(fft_eop),
    .fft_valid(fft_valid), .frame_err(frame_err)
  );

  always #10 clk_50m = ~clk_50m;

  typedef struct {
    logic [15:0] data;
    logic        sop;
    logic        eop;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  logic tb_err_in = 1'b0;
  logic exp_err_r;

  always @(posedge clk_50m) cyc <= cyc + 1;

  always @(posedge clk_50m or posedge rst)
    if (rst) exp_err_r <= 1'b0;
    else     exp_err_r <= tb_err_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  function automatic logic [15:0] mag(input logic signed [15:0] re, input logic signed [15:0] im);
    int a, b, mx, mn;
    a  = (int'(re) < 0) ? -int'(re) : int'(re);
    b  = (int'(im) < 0) ? -int'(im) : int'(im);
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return 16'(mx + (mn / 4) + (mn / 8));
  endfunction

  function automatic logic signed [15:0] pat_re(input int i);
    return 16'(i * 517 - 30000);
  endfunction

  function automatic logic signed [15:0] pat_im(input int i);
    return 16'(20000 - i * 311);
  endfunction

  always @(negedge clk_50m) begin
    if (!rst) begin
      exp_t e;
      check("frame_err", frame_err, exp_err_r);
      if (fft_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("data", fft_data, e.data);
          check("sop", fft_sop, e.sop);
          check("eop", fft_eop, e.eop);
          check("arrival_cycle", cyc, e.cyc);
        end
      end else begin
        check("sop_when_idle", fft_sop, 1'b0);
        check("eop_when_idle", fft_eop, 1'b0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_50m);
      #1;
    end
  endtask

  task automatic beat(input logic signed [15:0] re, input logic signed [15:0] im,
                      input logic s, input logic e,
                      input bit fwd, input bit xs, input bit xe, input bit xerr);
    src_real  = re;
    src_imag  = im;
    src_sop   = s;
    src_eop   = e;
    src_valid = 1'b1;
    tb_err_in = xerr;
    if (fwd) sb.push_back('{data: mag(re, im), sop: xs, eop: xe, cyc: cyc + 3});
    @(posedge clk_50m);
    #1;
    src_valid = 1'b0;
    src_sop   = 1'b0;
    src_eop   = 1'b0;
    tb_err_in = 1'b0;
  endtask

  // Drives n bins of a frame (src_eop on eop_bin, -1 for none); with gaps every third cycle is idle.
  task automatic run_frame(input int n, input int eop_bin, input bit gaps, input bit first_err);
    bit early, xe, xerr;
    for (int i = 0; i < n; i++) begin
      early = (i == eop_bin) && (i < OUT_BINS - 1);
      xe    = (i == OUT_BINS - 1) || early;
      xerr  = (i == 0 && first_err) || early;
      if (gaps && i > 0 && i % 2 == 0) idle(1);
      beat(pat_re(i), pat_im(i), i == 0, i == eop_bin, i < OUT_BINS, i == 0, xe, xerr);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_50m);
    #1;
    check("rst_valid", fft_valid, 1'b0);
    check("rst_data", fft_data, 16'd0);
    check("rst_sop", fft_sop, 1'b0);
    check("rst_eop", fft_eop, 1'b0);
    check("rst_err", frame_err, 1'b0);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 4; i++) beat(pat_re(i), pat_im(i), 1'b0, 1'b0, 0, 0, 0, 1);
    idle(4);

    beat(16'sd3000, -16'sd4000, 1'b1, 1'b0, 1, 1, 0, 0);
    idle(2);
    check("sop_beat_valid", fft_valid, 1'b1);
    check("sop_beat_data", fft_data, 16'd5125);
    check("sop_beat_sop", fft_sop, 1'b1);
    check("sop_beat_eop", fft_eop, 1'b0);
    beat(-16'sd32768, -16'sd32768, 1'b0, 1'b0, 1, 0, 0, 0);
    idle(2);
    check("max_neg_data", fft_data, 16'hB000);
    beat(16'sd0, 16'sd0, 1'b0, 1'b0, 1, 0, 0, 0);
    idle(2);
    check("zero_valid", fft_valid, 1'b1);
    check("zero_data", fft_data, 16'd0);
    beat(16'sd100, 16'sd100, 1'b0, 1'b1, 1, 0, 1, 1);
    idle(2);
    check("equal_data", fft_data, 16'd137);
    check("early_eop_tag", fft_eop, 1'b1);
    idle(3);

    run_frame(FFT_LEN, FFT_LEN - 1, 0, 0);
    run_frame(FFT_LEN, FFT_LEN - 1, 0, 0);
    idle(2);
    run_frame(FFT_LEN, FFT_LEN - 1, 1, 0);
    idle(2);
    run_frame(11, 10, 0, 0);
    idle(2);
    run_frame(20, -1, 0, 0);
    run_frame(FFT_LEN, FFT_LEN - 1, 0, 1);
    idle(2);

    run_frame(30, -1, 0, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", fft_valid, 1'b0);
    check("mid_rst_data", fft_data, 16'd0);
    check("mid_rst_sop", fft_sop, 1'b0);
    check("mid_rst_eop", fft_eop, 1'b0);
    check("mid_rst_err", frame_err, 1'b0);
    sb.delete();
    idle(2);
    rst = 1'b0;
    idle(1);
    for (int i = 30; i < 33; i++) beat(pat_re(i), pat_im(i), 1'b0, 1'b0, 0, 0, 0, 1);
    run_frame(FFT_LEN, FFT_LEN - 1, 0, 0);

    for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1);
    idle(2);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
